// File: rtl/clk_run_timer.sv
// Run-cycle timer driven by an upstream clock controller's START/STOP state.
// Counts START cycles up to a programmable limit, or free-runs when the limit is 0.
module clk_run_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             state_in,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             clear,
  output logic [CNT_W-1:0] count,
  output logic             running,
  output logic             done,
  output logic             done_pulse,
  output logic             overflow
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic START = 1'b0;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] limit, limit_nxt;
  logic [CNT_W-1:0] count_nxt;
  logic [CNT_W-1:0] count_inc;
  logic             ovf_nxt;
  logic             free_run;

  assign count_inc = count + {{(CNT_W-1){1'b0}}, 1'b1};
  assign free_run  = (limit == '0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Counter, limit and every output are registered from the next-state values,
  // so running/done track the state register with no input-to-output path.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count      <= '0;
      limit      <= '0;
      running    <= 1'b0;
      done       <= 1'b0;
      done_pulse <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      count      <= count_nxt;
      limit      <= limit_nxt;
      running    <= (state_nxt == S_RUN);
      done       <= (state_nxt == S_DONE);
      done_pulse <= (state_nxt == S_DONE) && (state != S_DONE);
      overflow   <= ovf_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    limit_nxt = limit;
    ovf_nxt   = overflow;
    if (clear) begin
      state_nxt = S_IDLE;
      count_nxt = '0;
      ovf_nxt   = 1'b0;
    end else begin
      if (load && (state != S_RUN)) begin
        limit_nxt = load_val;
      end
      case (state)
        S_IDLE: begin
          if (state_in == START) begin
            state_nxt = S_RUN;
          end
        end
        S_RUN: begin
          if (state_in == START) begin
            if (!free_run && (count_inc == limit)) begin
              count_nxt = limit;
              state_nxt = S_DONE;
            end else begin
              count_nxt = count_inc;
              if (free_run && (&count)) begin
                ovf_nxt = 1'b1;
              end
            end
          end else begin
            state_nxt = S_HOLD;
          end
        end
        S_HOLD: begin
          // A limit lowered to or below the held count finishes without counting.
          if (state_in == START) begin
            if (!free_run && (limit <= count)) begin
              state_nxt = S_DONE;
            end else begin
              state_nxt = S_RUN;
            end
          end
        end
        S_DONE: begin
          state_nxt = S_DONE;
        end
        default: begin
          state_nxt = S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clk_run_timer.sv
// Directed self-checking bench for clk_run_timer: limit run, hold, free-run,
// load in hold/run, clear priority and asynchronous reset.
module tb_clk_run_timer;

  logic       clk;
  logic       resetn;
  logic       state_in;
  logic       load;
  logic [7:0] load_val;
  logic       clear;
  logic [7:0] count;
  logic       running;
  logic       done;
  logic       done_pulse;
  logic       overflow;

  int errors;
  int checks;

  clk_run_timer #(.CNT_W(8)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .state_in   (state_in),
    .load       (load),
    .load_val   (load_val),
    .clear      (clear),
    .count      (count),
    .running    (running),
    .done       (done),
    .done_pulse (done_pulse),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic load_limit(input logic [7:0] v);
    state_in = 1'b1;
    load     = 1'b1;
    load_val = v;
    tick();
    load     = 1'b0;
  endtask

  task automatic test_reset();
    resetn   = 1'b0;
    state_in = 1'b1;
    load     = 1'b0;
    load_val = 8'd0;
    clear    = 1'b0;
    #12;
    checks++;
    if ({count, running, done, done_pulse, overflow} !== 12'd0) begin
      errors++;
      $display("FAIL reset_values: got cnt=%0d run=%b done=%b dp=%b ovf=%b, want all 0",
               count, running, done, done_pulse, overflow);
    end
    resetn = 1'b1;
    tick();
    checks++;
    if ({count, running, done} !== 10'd0) begin
      errors++;
      $display("FAIL reset_idle_stop: got cnt=%0d run=%b done=%b, want 0/0/0", count, running, done);
    end
  endtask

  task automatic test_basic_limit();
    load_limit(8'd5);
    state_in = 1'b0;
    tick();
    checks++;
    if (running !== 1'b1 || count !== 8'd0) begin
      errors++;
      $display("FAIL basic_start: got run=%b cnt=%0d, want 1/0", running, count);
    end
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks++;
      if (count !== 8'(i) || running !== 1'b1 || done_pulse !== 1'b0) begin
        errors++;
        $display("FAIL basic_count: got cnt=%0d run=%b dp=%b, want %0d/1/0", count, running, done_pulse, i);
      end
    end
    tick();
    checks++;
    if (count !== 8'd5 || done !== 1'b1 || done_pulse !== 1'b1 || running !== 1'b0) begin
      errors++;
      $display("FAIL basic_done: got cnt=%0d done=%b dp=%b run=%b, want 5/1/1/0",
               count, done, done_pulse, running);
    end
    state_in = 1'b1;
    tick();
    checks++;
    if (count !== 8'd5 || done !== 1'b1 || done_pulse !== 1'b0) begin
      errors++;
      $display("FAIL basic_done_hold: got cnt=%0d done=%b dp=%b, want 5/1/0", count, done, done_pulse);
    end
    load     = 1'b1;
    load_val = 8'd2;
    state_in = 1'b0;
    tick();
    load = 1'b0;
    tick();
    checks++;
    if (count !== 8'd5 || done !== 1'b1 || running !== 1'b0 || done_pulse !== 1'b0) begin
      errors++;
      $display("FAIL done_load_stays: got cnt=%0d done=%b run=%b dp=%b, want 5/1/0/0",
               count, done, running, done_pulse);
    end
  endtask

  task automatic test_hold();
    logic [7:0] prev;
    int         incs;
    do_clear();
    load_limit(8'd10);
    incs = 0;
    for (int k = 0; k < 100 && !done; k++) begin
      state_in = ((k % 4) == 1) || ((k % 4) == 2);
      prev     = count;
      tick();
      if (count == prev + 8'd1) incs++;
      if (state_in) begin
        checks++;
        if (count !== prev || running !== 1'b0 || done !== 1'b0) begin
          errors++;
          $display("FAIL hold_frozen: got cnt=%0d run=%b done=%b, want cnt=%0d run=0 done=0",
                   count, running, done, prev);
        end
      end
    end
    checks++;
    if (done !== 1'b1 || count !== 8'd10 || incs != 10) begin
      errors++;
      $display("FAIL hold_total: got done=%b cnt=%0d incs=%0d, want 1/10/10", done, count, incs);
    end
  endtask

  task automatic test_free_run();
    logic [7:0] exp_cnt;
    logic       exp_ovf;
    do_clear();
    load_limit(8'd0);
    state_in = 1'b0;
    tick();
    for (int i = 1; i <= 257; i++) begin
      tick();
      exp_cnt = 8'(i % 256);
      exp_ovf = (i >= 256);
      checks++;
      if (count !== exp_cnt || overflow !== exp_ovf || done !== 1'b0) begin
        errors++;
        $display("FAIL free_run: cycle %0d got cnt=%0d ovf=%b done=%b, want %0d/%b/0",
                 i, count, overflow, done, exp_cnt, exp_ovf);
      end
    end
    do_clear();
    checks++;
    if (overflow !== 1'b0 || count !== 8'd0 || running !== 1'b0) begin
      errors++;
      $display("FAIL free_run_clear: got ovf=%b cnt=%0d run=%b, want 0/0/0", overflow, count, running);
    end
  endtask

  task automatic test_hold_load();
    do_clear();
    load_limit(8'd20);
    state_in = 1'b0;
    tick();
    for (int i = 0; i < 7; i++) tick();
    state_in = 1'b1;
    tick();
    checks++;
    if (count !== 8'd7 || running !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL hold_load_enter: got cnt=%0d run=%b done=%b, want 7/0/0", count, running, done);
    end
    load     = 1'b1;
    load_val = 8'd4;
    tick();
    load = 1'b0;
    checks++;
    if (count !== 8'd7 || running !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL hold_load_wait: got cnt=%0d run=%b done=%b, want 7/0/0", count, running, done);
    end
    state_in = 1'b0;
    tick();
    checks++;
    if (count !== 8'd7 || done !== 1'b1 || done_pulse !== 1'b1 || running !== 1'b0) begin
      errors++;
      $display("FAIL hold_load_done: got cnt=%0d done=%b dp=%b run=%b, want 7/1/1/0",
               count, done, done_pulse, running);
    end
  endtask

  task automatic test_run_load_clear();
    do_clear();
    load_limit(8'd9);
    state_in = 1'b0;
    tick();
    tick();
    tick();
    load     = 1'b1;
    load_val = 8'd3;
    tick();
    load = 1'b0;
    for (int i = 4; i <= 8; i++) begin
      tick();
      checks++;
      if (count !== 8'(i) || done !== 1'b0) begin
        errors++;
        $display("FAIL run_load_ignored: got cnt=%0d done=%b, want %0d/0", count, done, i);
      end
    end
    tick();
    checks++;
    if (count !== 8'd9 || done !== 1'b1 || done_pulse !== 1'b1) begin
      errors++;
      $display("FAIL run_load_done: got cnt=%0d done=%b dp=%b, want 9/1/1", count, done, done_pulse);
    end
    clear    = 1'b1;
    load     = 1'b1;
    load_val = 8'd3;
    tick();
    clear = 1'b0;
    load  = 1'b0;
    checks++;
    if ({count, running, done, done_pulse, overflow} !== 12'd0) begin
      errors++;
      $display("FAIL clear_load: got cnt=%0d run=%b done=%b dp=%b ovf=%b, want all 0",
               count, running, done, done_pulse, overflow);
    end
    tick();
    for (int i = 0; i < 8; i++) tick();
    checks++;
    if (count !== 8'd8 || done !== 1'b0) begin
      errors++;
      $display("FAIL clear_keeps_limit_pre: got cnt=%0d done=%b, want 8/0", count, done);
    end
    tick();
    checks++;
    if (count !== 8'd9 || done !== 1'b1) begin
      errors++;
      $display("FAIL clear_keeps_limit: got cnt=%0d done=%b, want 9/1", count, done);
    end
  endtask

  task automatic test_async_reset();
    do_clear();
    load_limit(8'd9);
    state_in = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (count !== 8'd3 || running !== 1'b1) begin
      errors++;
      $display("FAIL areset_pre: got cnt=%0d run=%b, want 3/1", count, running);
    end
    #2;
    resetn = 1'b0;
    #1;
    checks++;
    if ({count, running, done, done_pulse, overflow} !== 12'd0) begin
      errors++;
      $display("FAIL areset_immediate: got cnt=%0d run=%b done=%b dp=%b ovf=%b, want all 0",
               count, running, done, done_pulse, overflow);
    end
    @(negedge clk);
    resetn = 1'b1;
    tick();
    for (int i = 1; i <= 10; i++) begin
      tick();
      checks++;
      if (done_pulse !== 1'b0 || done !== 1'b0 || count !== 8'(i)) begin
        errors++;
        $display("FAIL areset_limit_zero: got cnt=%0d done=%b dp=%b, want %0d/0/0",
                 count, done, done_pulse, i);
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_basic_limit();
    test_hold();
    test_free_run();
    test_hold_load();
    test_run_load_clear();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
